// File: rtl/ws_strip_sequencer_pkg.sv
// Shared types and constants for the WS-style LED strip sequencer.
// Holds the FSM state encoding, colour layout and the colour unpack helper.
package ws_strip_sequencer_pkg;

    localparam int COLOR_W  = 24;
    localparam int MAX_LEDS = 256;

    localparam int RED_HI = 23;
    localparam int RED_LO = 16;
    localparam int GRN_HI = 15;
    localparam int GRN_LO = 8;
    localparam int BLU_HI = 7;
    localparam int BLU_LO = 0;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_ISSUE      = 3'd1;
    localparam state_t ST_WAIT_ACK   = 3'd2;
    localparam state_t ST_WAIT_DONE  = 3'd3;
    localparam state_t ST_LATCH      = 3'd4;
    localparam state_t ST_LATCH_ACK  = 3'd5;
    localparam state_t ST_LATCH_WAIT = 3'd6;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } color_t;

    function automatic color_t unpack_color(input logic [COLOR_W-1:0] c);
        color_t res;
        res.r = c[RED_HI:RED_LO];
        res.g = c[GRN_HI:GRN_LO];
        res.b = c[BLU_HI:BLU_LO];
        return res;
    endfunction

endpackage

// File: rtl/ws_strip_sequencer_pixel_ram.sv
// Per-pixel colour store: one synchronous write port, one asynchronous read port.
// Out-of-range writes are dropped so they can never alias onto a real pixel.
module ws_pixel_ram
    import ws_strip_sequencer_pkg::*;
#(
    parameter int NUM_LEDS = 10,
    parameter int ADDR_W   = 4
) (
    input  logic               clk,
    input  logic               wr_en_i,
    input  logic [7:0]         wr_addr_i,
    input  logic [COLOR_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0]  rd_addr_i,
    output logic [COLOR_W-1:0] rd_data_o
);

    logic [COLOR_W-1:0] mem [NUM_LEDS];
    logic               inRange;

    assign inRange = ({1'b0, wr_addr_i} < 9'(NUM_LEDS));

    always_ff @(posedge clk) begin
        if (wr_en_i && inRange) begin
            mem[wr_addr_i[ADDR_W-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o = mem[rd_addr_i];

endmodule

// File: rtl/ws_strip_sequencer.sv
// Frame sequencer feeding a WS-style strip driver one pixel at a time,
// with fill mode, a one-deep pending start and an optional auto-refresh timer.
module ws_strip_sequencer
    import ws_strip_sequencer_pkg::*;
#(
    parameter int NUM_LEDS = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en_i,
    input  logic [7:0]         wr_addr_i,
    input  logic [COLOR_W-1:0] wr_data_i,
    input  logic               start_i,
    input  logic               fill_en_i,
    input  logic [COLOR_W-1:0] fill_color_i,
    input  logic [31:0]        refresh_period_i,
    input  logic               ws_ready_i,
    output logic               busy_o,
    output logic               frame_done_o,
    output logic [7:0]         ws_r_o,
    output logic [7:0]         ws_g_o,
    output logic [7:0]         ws_b_o,
    output logic               ws_load_o,
    output logic               ws_reset_o
);

    localparam int         RAM_AW   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [7:0] LAST_IDX = 8'(NUM_LEDS - 1);

    state_t             state_q, state_d;
    logic [7:0]         idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               pending_q, pending_d;
    logic               fill_sel_q, fill_sel_d;
    logic               frame_done_q, frame_done_d;
    logic               load_q, load_d;
    logic               reset_q, reset_d;
    color_t             color_q, color_d;
    logic [31:0]        timer_q, timer_d;
    logic               autoReq;
    logic               frameStart;
    logic [COLOR_W-1:0] pixelData;

    ws_pixel_ram #(
        .NUM_LEDS (NUM_LEDS),
        .ADDR_W   (RAM_AW)
    ) u_pixel_ram (
        .clk       (clk),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .rd_addr_i (idx_q[RAM_AW-1:0]),
        .rd_data_o (pixelData)
    );

    // Auto-refresh timer measures from the most recent frame start, manual or automatic.
    always_comb begin
        autoReq = 1'b0;
        timer_d = timer_q;
        if (refresh_period_i == 32'd0) begin
            timer_d = 32'd0;
        end else if (timer_q >= refresh_period_i - 32'd1) begin
            autoReq = 1'b1;
            timer_d = 32'd0;
        end else begin
            timer_d = timer_q + 32'd1;
        end
        if (frameStart) begin
            timer_d = 32'd0;
        end
    end

    assign frameStart = (state_q == ST_IDLE) && (start_i || pending_q || autoReq);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        busy_d       = busy_q;
        pending_d    = pending_q;
        fill_sel_d   = fill_sel_q;
        frame_done_d = 1'b0;
        load_d       = 1'b0;
        reset_d      = 1'b0;
        color_d      = color_q;

        if (busy_q && (start_i || autoReq)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (frameStart) begin
                    state_d    = ST_ISSUE;
                    idx_d      = 8'd0;
                    busy_d     = 1'b1;
                    fill_sel_d = fill_en_i;
                    pending_d  = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (ws_ready_i) begin
                    color_d = fill_sel_q ? unpack_color(fill_color_i) : unpack_color(pixelData);
                    load_d  = 1'b1;
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (!ws_ready_i) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (ws_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_LATCH;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_LATCH: begin
                if (ws_ready_i) begin
                    reset_d = 1'b1;
                    state_d = ST_LATCH_ACK;
                end
            end
            ST_LATCH_ACK: begin
                if (!ws_ready_i) begin
                    state_d = ST_LATCH_WAIT;
                end
            end
            ST_LATCH_WAIT: begin
                if (ws_ready_i) begin
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= 8'd0;
            busy_q       <= 1'b0;
            pending_q    <= 1'b0;
            fill_sel_q   <= 1'b0;
            frame_done_q <= 1'b0;
            load_q       <= 1'b0;
            reset_q      <= 1'b0;
            color_q      <= '0;
            timer_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            busy_q       <= busy_d;
            pending_q    <= pending_d;
            fill_sel_q   <= fill_sel_d;
            frame_done_q <= frame_done_d;
            load_q       <= load_d;
            reset_q      <= reset_d;
            color_q      <= color_d;
            timer_q      <= timer_d;
        end
    end

    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;
    assign ws_load_o    = load_q;
    assign ws_reset_o   = reset_q;
    assign ws_r_o       = color_q.r;
    assign ws_g_o       = color_q.g;
    assign ws_b_o       = color_q.b;

endmodule
